// File: rtl/fft_sched_pkg.sv
// Shared types and elaboration-time helpers for the FFT butterfly scheduler.
package fft_sched_pkg;

  // Widest transform supported (2^10 points); bounds the bit-reverse helper.
  localparam int MAX_N_LOG2 = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Cycles from issue to write-back: one registered RAM read plus the butterfly.
  function automatic int pipe_depth(input int bfly_lat);
    return 1 + bfly_lat;
  endfunction

  // ceil(log2(n)), never below 1, so a stage index always has at least one bit.
  function automatic int stage_width(input int n_log2);
    int w;
    w = 1;
    for (int i = 1; i < 16; i++) begin
      if ((1 << i) < n_log2) w = i + 1;
    end
    return w;
  endfunction

  // Reverse the low 'width' bits of v; bits above 'width' come back as zero.
  function automatic logic [MAX_N_LOG2-1:0] bitrev(input logic [MAX_N_LOG2-1:0] v,
                                                   input int width);
    logic [MAX_N_LOG2-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_N_LOG2; i++) begin
      if (i < width) r[i] = v[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational radix-2 DIT address generator: (stage, k) -> operand pair and twiddle index.
module fft_addr_gen
  import fft_sched_pkg::*;
#(
  parameter int N_LOG2 = 5,
  parameter int SW     = 3
) (
  input  logic [SW-1:0]     stage,
  input  logic [N_LOG2-2:0] k,
  output logic [N_LOG2-1:0] addr_a,
  output logic [N_LOG2-1:0] addr_b,
  output logic [N_LOG2-2:0] tw_addr
);

  localparam int AW = N_LOG2;
  localparam int KW = N_LOG2 - 1;

  logic [AW-1:0] span;
  logic [KW-1:0] pos_mask;
  logic [KW-1:0] pos;
  logic [KW-1:0] grp;
  logic [SW-1:0] tw_shift;

  // In the last stage 1<<stage wraps to 0 in KW bits, so the mask becomes all ones as required.
  always_comb begin
    span     = AW'(1) << stage;
    pos_mask = (KW'(1) << stage) - KW'(1);
    pos      = k & pos_mask;
    grp      = k >> stage;
    addr_a   = ({grp, 1'b0} << stage) | {1'b0, pos};
    addr_b   = addr_a + span;
    tw_shift = SW'(N_LOG2 - 1) - stage;
    tw_addr  = pos << tw_shift;
  end

endmodule

// File: rtl/fft_bfly_scheduler.sv
// Issue sequencer for an in-place radix-2 DIT FFT: read addresses, twiddle index,
// operand-valid/precision alignment and delayed write-back addresses.
// Optional macro FFT_SCHED_BITREV_EN: bit-reverse stage-0 read addresses so input
// can be stored in natural order (write-back addresses are never reversed).
module fft_bfly_scheduler
  import fft_sched_pkg::*;
#(
  parameter int                N_LOG2         = 5,
  parameter int                BFLY_LAT       = 1,
  parameter logic [N_LOG2-1:0] STAGE_FP8_MASK = '1,
  localparam int               SW             = stage_width(N_LOG2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              bfly_valid,
  output logic              bfly_fp8,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_x,
  output logic [N_LOG2-1:0] wr_addr_y,
  output logic [SW-1:0]     stage
);

  localparam int            PIPE       = pipe_depth(BFLY_LAT);
  localparam int            KW         = N_LOG2 - 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(N_LOG2 - 1);
  localparam logic [2:0]    DRAIN_LAST = 3'(PIPE - 1);

  state_t          state_reg, state_next;
  logic [SW-1:0]   stage_reg, stage_next;
  logic [KW-1:0]   k_reg, k_next;
  logic [2:0]      drain_reg, drain_next;

  logic            issue;
  logic [N_LOG2-1:0] gen_a, gen_b;
  logic [KW-1:0]   gen_tw;
  logic [N_LOG2-1:0] nat_a, nat_b;

  logic            bfly_valid_reg, bfly_fp8_reg;

  logic            dl_valid [PIPE];
  logic [N_LOG2-1:0] dl_a   [PIPE];
  logic [N_LOG2-1:0] dl_b   [PIPE];

  fft_addr_gen #(
    .N_LOG2(N_LOG2),
    .SW    (SW)
  ) u_addr_gen (
    .stage  (stage_reg),
    .k      (k_reg),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw_addr(gen_tw)
  );

  // FSM state, stage, butterfly index and drain counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      stage_reg <= '0;
      k_reg     <= '0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      stage_reg <= stage_next;
      k_reg     <= k_next;
      drain_reg <= drain_next;
    end
  end

  // Next-state logic: one butterfly per RUN cycle, PIPE-cycle DRAIN between stages.
  always_comb begin
    state_next = state_reg;
    stage_next = stage_reg;
    k_next     = k_reg;
    drain_next = drain_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = RUN;
          stage_next = '0;
          k_next     = '0;
        end else if (state_reg == DONE) begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (&k_reg) begin
          state_next = DRAIN;
          k_next     = '0;
          drain_next = '0;
        end else begin
          k_next = k_reg + KW'(1);
        end
      end
      DRAIN: begin
        if (drain_reg == DRAIN_LAST) begin
          if (stage_reg == LAST_STAGE) begin
            state_next = DONE;
          end else begin
            state_next = RUN;
            stage_next = stage_reg + SW'(1);
          end
        end else begin
          drain_next = drain_reg + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Issue-side outputs; addresses are forced to zero outside RUN.
  always_comb begin
    issue = (state_reg == RUN);
    nat_a = issue ? gen_a : '0;
    nat_b = issue ? gen_b : '0;
`ifdef FFT_SCHED_BITREV_EN
    if (issue && stage_reg == '0) begin
      rd_addr_a = N_LOG2'(bitrev(MAX_N_LOG2'(gen_a), N_LOG2));
      rd_addr_b = N_LOG2'(bitrev(MAX_N_LOG2'(gen_b), N_LOG2));
    end else begin
      rd_addr_a = nat_a;
      rd_addr_b = nat_b;
    end
`else
    rd_addr_a = nat_a;
    rd_addr_b = nat_b;
`endif
    rd_en   = issue;
    tw_addr = issue ? gen_tw : '0;
    busy    = (state_reg == RUN) || (state_reg == DRAIN);
    done    = (state_reg == DONE);
    stage   = stage_reg;
  end

  // Operands land at the butterfly one cycle after the RAM/ROM read strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      bfly_valid_reg <= 1'b0;
      bfly_fp8_reg   <= 1'b0;
    end else begin
      bfly_valid_reg <= issue;
      bfly_fp8_reg   <= issue & STAGE_FP8_MASK[stage_reg];
    end
  end

  assign bfly_valid = bfly_valid_reg;
  assign bfly_fp8   = bfly_fp8_reg;

  // Head of the write-back delay line takes the un-reversed pair being issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_valid[0] <= 1'b0;
      dl_a[0]     <= '0;
      dl_b[0]     <= '0;
    end else begin
      dl_valid[0] <= issue;
      dl_a[0]     <= nat_a;
      dl_b[0]     <= nat_b;
    end
  end

  generate
    for (genvar gi = 1; gi < PIPE; gi++) begin : g_dl
      // Remaining delay-line taps; reset drops anything in flight.
      always_ff @(posedge clk) begin
        if (rst) begin
          dl_valid[gi] <= 1'b0;
          dl_a[gi]     <= '0;
          dl_b[gi]     <= '0;
        end else begin
          dl_valid[gi] <= dl_valid[gi-1];
          dl_a[gi]     <= dl_a[gi-1];
          dl_b[gi]     <= dl_b[gi-1];
        end
      end
    end
  endgenerate

  assign wr_en     = dl_valid[PIPE-1];
  assign wr_addr_x = dl_a[PIPE-1];
  assign wr_addr_y = dl_b[PIPE-1];

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// Directed bench: 8-point / BFLY_LAT=1 / mask 101 schedule, restart in DONE, reset
// with writes in flight, plus a 16-point / BFLY_LAT=0 instance for timing and addressing.
module tb_fft_bfly_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start2;

  // 8-point instance
  logic       busy, done, rd_en, bfly_valid, bfly_fp8, wr_en;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_x, wr_addr_y;
  logic [1:0] tw_addr, stage;

  // 16-point instance
  logic       busy2, done2, rd_en2, bfly_valid2, bfly_fp82, wr_en2;
  logic [3:0] rd_addr_a2, rd_addr_b2, wr_addr_x2, wr_addr_y2;
  logic [2:0] tw_addr2;
  logic [1:0] stage2;

  fft_bfly_scheduler #(.N_LOG2(3), .BFLY_LAT(1), .STAGE_FP8_MASK(3'b101)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .bfly_valid(bfly_valid), .bfly_fp8(bfly_fp8), .wr_en(wr_en),
    .wr_addr_x(wr_addr_x), .wr_addr_y(wr_addr_y), .stage(stage)
  );

  fft_bfly_scheduler #(.N_LOG2(4), .BFLY_LAT(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .rd_en(rd_en2),
    .rd_addr_a(rd_addr_a2), .rd_addr_b(rd_addr_b2), .tw_addr(tw_addr2),
    .bfly_valid(bfly_valid2), .bfly_fp8(bfly_fp82), .wr_en(wr_en2),
    .wr_addr_x(wr_addr_x2), .wr_addr_y(wr_addr_y2), .stage(stage2)
  );

  int total = 0;
  int bad   = 0;

  // Hand-computed 8-point schedule, index = stage*4 + k (natural order).
  int wr_a_tbl [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int wr_b_tbl [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int tw_tbl   [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};
`ifdef FFT_SCHED_BITREV_EN
  int rd_a_tbl [12] = '{0, 2, 1, 3,  0, 1, 4, 5,  0, 1, 2, 3};
  int rd_b_tbl [12] = '{4, 6, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
`else
  int rd_a_tbl [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int rd_b_tbl [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
`endif
  // Stage precision for mask 3'b101.
  int fp8_tbl [3] = '{1, 0, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue slot for cycle c of the 8-point run: 4 issues then 2 drain cycles per stage.
  function automatic int issue_idx(input int c);
    int r;
    if (c < 1 || c > 18) return -1;
    r = (c - 1) % 6;
    if (r >= 4) return -1;
    return ((c - 1) / 6) * 4 + r;
  endfunction

  initial begin
    int idx, pidx, widx;
    int rd_cnt, wr_cnt, done_cnt, done_cyc;

    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_bfly_valid", bfly_valid, 0);
    check("rst_bfly_fp8", bfly_fp8, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_a", rd_addr_a, 0);
    check("rst_rd_b", rd_addr_b, 0);
    check("rst_tw", tw_addr, 0);
    check("rst_wr_x", wr_addr_x, 0);
    check("rst_wr_y", wr_addr_y, 0);
    check("rst_stage", stage, 0);
    rst = 1'b0;
    tick();

    // Full 8-point transform; start pulses in cycle 2 (ignored) and in the DONE cycle.
    start = 1'b1;
    tick();
    for (int c = 1; c <= 19; c++) begin
      idx  = issue_idx(c);
      pidx = issue_idx(c - 1);
      widx = issue_idx(c - 2);
      check("rd_en", rd_en, (idx >= 0) ? 1 : 0);
      check("busy", busy, (c <= 18) ? 1 : 0);
      check("done", done, (c == 19) ? 1 : 0);
      if (idx >= 0) begin
        $display("issue cyc=%0d stage=%0d k=%0d a=%0d b=%0d tw=%0d",
                 c, stage, idx % 4, rd_addr_a, rd_addr_b, tw_addr);
        check("stage", stage, idx / 4);
        check("rd_addr_a", rd_addr_a, rd_a_tbl[idx]);
        check("rd_addr_b", rd_addr_b, rd_b_tbl[idx]);
        check("tw_addr", tw_addr, tw_tbl[idx]);
      end
      check("bfly_valid", bfly_valid, (pidx >= 0) ? 1 : 0);
      check("bfly_fp8", bfly_fp8, (pidx >= 0) ? fp8_tbl[pidx / 4] : 0);
      check("wr_en", wr_en, (widx >= 0) ? 1 : 0);
      if (widx >= 0) begin
        check("wr_addr_x", wr_addr_x, wr_a_tbl[widx]);
        check("wr_addr_y", wr_addr_y, wr_b_tbl[widx]);
      end
      start = (c == 2 || c == 19) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;

    // Restart accepted in DONE: first issue of the new run is stage 0, k 0.
    check("restart_rd_en", rd_en, 1);
    check("restart_busy", busy, 1);
    check("restart_done", done, 0);
    check("restart_stage", stage, 0);
    check("restart_rd_a", rd_addr_a, rd_a_tbl[0]);
    check("restart_rd_b", rd_addr_b, rd_b_tbl[0]);
    check("restart_wr_en", wr_en, 0);

    // Advance into stage 1 with two write-backs in flight, then reset.
    repeat (8) tick();
    check("inflight_wr_en", wr_en, 1);
    check("inflight_wr_x", wr_addr_x, 0);
    check("inflight_wr_y", wr_addr_y, 2);
    check("inflight_stage", stage, 1);
    check("inflight_rd_a", rd_addr_a, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_rd_en", rd_en, 0);
    check("post_rst_rd_a", rd_addr_a, 0);
    check("post_rst_rd_b", rd_addr_b, 0);
    check("post_rst_tw", tw_addr, 0);
    check("post_rst_bfly_valid", bfly_valid, 0);
    check("post_rst_bfly_fp8", bfly_fp8, 0);
    check("post_rst_wr_en", wr_en, 0);
    check("post_rst_wr_x", wr_addr_x, 0);
    check("post_rst_wr_y", wr_addr_y, 0);
    check("post_rst_stage", stage, 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("quiet_wr_en", wr_en, 0);
      check("quiet_rd_en", rd_en, 0);
    end

    // 16-point, BFLY_LAT=0: done at 4*(8+1)+1 = 37, write-back one cycle after issue.
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (rd_en2) rd_cnt++;
      if (wr_en2) wr_cnt++;
      if (done2) begin
        done_cnt++;
        done_cyc = c;
        check("n16_busy_at_done", busy2, 0);
      end
      if (c == 15) begin
        check("n16_s1k5_stage", stage2, 1);
        check("n16_s1k5_a", rd_addr_a2, 9);
        check("n16_s1k5_b", rd_addr_b2, 11);
        check("n16_s1k5_tw", tw_addr2, 4);
      end
      if (c == 35) begin
        check("n16_s3k7_stage", stage2, 3);
        check("n16_s3k7_a", rd_addr_a2, 7);
        check("n16_s3k7_b", rd_addr_b2, 15);
        check("n16_s3k7_tw", tw_addr2, 7);
      end
      if (c == 36) begin
        check("n16_wb_en", wr_en2, 1);
        check("n16_wb_x", wr_addr_x2, 7);
        check("n16_wb_y", wr_addr_y2, 15);
        check("n16_bfly_valid", bfly_valid2, 1);
      end
      tick();
    end
    check("n16_rd_count", rd_cnt, 32);
    check("n16_wr_count", wr_cnt, 32);
    check("n16_done_count", done_cnt, 1);
    check("n16_done_cycle", done_cyc, 37);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_bfly_scheduler.md
# fft_bfly_scheduler

Sequencing stage that drives the butterfly datapath for an in-place radix-2 DIT FFT of 2^N_LOG2 points. It issues paired data-memory read addresses and twiddle-ROM addresses, and asserts an issue-valid aligned with the operands arriving at the butterfly. It also emits the per-stage precision selection and delays the write-back addresses so that X/Y return to the A/B locations. It sits directly upstream of the butterfly wrapper, between the data RAM / twiddle ROM and the butterfly inputs, and owns the write port of the data RAM.

## Interface
- N_LOG2, 5, log2 of FFT length; legal 2..10
- BFLY_LAT, 1, butterfly latency in cycles from operand valid to X/Y valid; legal 0..4
- STAGE_FP8_MASK, all ones, bit s = 1 selects FP8 multiply and add for stage s, 0 selects FP4
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a transform; accepted only when busy = 0
- busy  out  1  transform in progress
- done  out  1  one-cycle pulse after final write-back
- rd_en  out  1  data RAM and twiddle ROM read strobe
- rd_addr_a  out  N_LOG2  upper butterfly operand address
- rd_addr_b  out  N_LOG2  lower butterfly operand address
- tw_addr  out  N_LOG2-1  twiddle ROM address
- bfly_valid  out  1  RAM/ROM outputs valid at butterfly inputs this cycle
- bfly_fp8  out  1  precision select for the current operands, aligned with bfly_valid
- wr_en  out  1  write X/Y back this cycle
- wr_addr_x  out  N_LOG2  destination of X
- wr_addr_y  out  N_LOG2  destination of Y
- stage  out  clog2(N_LOG2)  current stage index (debug)

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
  - IDLE: start → RUN, with stage = 0 and k = 0.
  - RUN: issues one butterfly per cycle, k = 0..N/2-1. After k = N/2-1 → DRAIN.
  - DRAIN: lasts PIPE = 1 + BFLY_LAT cycles. It then goes to RUN with stage+1, or to DONE after the last stage.
  - DONE: lasts one cycle, then → IDLE. start in DONE is accepted and goes to RUN.
- Addressing for stage s and butterfly k:
  - span = 1<<s, pos = k & (span-1), grp = k >> s
  - addr_a = (grp << (s+1)) | pos
  - addr_b = addr_a + span
  - tw_addr = pos << (N_LOG2-1-s)
  - All address arithmetic is unsigned, with no overflow by construction.
- Write-back: rd_addr_a, rd_addr_b and the precision bit enter a PIPE-deep shift register. Its output drives wr_addr_x, wr_addr_y and wr_en.
- bfly_fp8 = STAGE_FP8_MASK[s] of the issuing stage, delayed one cycle.
- start while busy = 1 is ignored.
- rst in any state:
  - → IDLE
  - every output goes to 0
  - pending write-backs in the delay line are discarded, with no wr_en after reset.
- The RAM is write-then-visible: a write in cycle c is readable from cycle c+1. DRAIN guarantees the last write of stage s precedes the first read of stage s+1.

## Timing
- Reset values: busy, done, rd_en, bfly_valid, bfly_fp8 and wr_en are 0. All addresses and stage are 0.
- start sampled high at cycle 0 → busy = 1 and the first rd_en at cycle 1.
- Issue at cycle t (rd_en):
  - bfly_valid is high at t+1.
  - wr_en with its matching addresses is high at t+PIPE.
- done is high at cycle N_LOG2·(N/2 + PIPE) + 1. busy is 0 in that same cycle.
- Issue throughput is one butterfly per clock within a stage. There are no bubbles except DRAIN.

## Configuration
- The macro FFT_SCHED_BITREV_EN controls stage-0 read addressing.
- Defined: stage-0 rd_addr_a and rd_addr_b are bit-reversed over N_LOG2 bits, so input is stored in natural order. wr addresses stay un-reversed, which makes the computation out-of-place-reordered into the in-place layout.
- Undefined: input is already bit-reversed in RAM, and addresses are used unchanged in all stages.

## Structure
- Package fft_sched_pkg holds:
  - the state enum
  - the PIPE constant function
  - the bitrev function
  - the clog2 helper for the stage width
- Sub-module fft_addr_gen is combinational. It takes (stage, k) and produces addr_a, addr_b and tw_addr. It is instantiated once.

## Test plan
- N_LOG2=3, BFLY_LAT=1, start at cycle 0 → rd_en high in cycles 1-4, 7-10 and 13-16; done pulses at cycle 19.
- Same configuration, addresses:
  - stage 0, k=2 → a=4, b=5, tw=0
  - stage 1, k=1 → a=1, b=3, tw=2
  - stage 2, k=3 → a=3, b=7, tw=3
  - each pair appears on wr_addr_x/y exactly 2 cycles after issue
- STAGE_FP8_MASK=3'b101 → bfly_fp8 is 1, 0, 1 across stages, aligned with bfly_valid.
- rst asserted in stage 1 with writes in flight → all outputs 0 on the next cycle; no wr_en until a new start.
- start pulsed mid-RUN and again in the DONE cycle → the first is ignored; the second restarts with rd_en at the following cycle, stage 0, k 0.
- FFT_SCHED_BITREV_EN defined, N_LOG2=3 → stage-0 k=1 reads a=2, b=6, while stage 1 is unchanged.
